bram_load_sequencer: RTL and testbench
======================================

Name: bram_load_sequencer

Overview:
- Parametrised loader that takes one tagged input stream and fills NUM_CH on-chip BRAMs (H col_idx, H value, node_info, Weight, a, ...).
- Generates each channel's write enable, write address and load_done internally, so the host no longer drives them per BRAM.
- Sits between the host/DMA interface and the BRAM instances in the accelerator top. Its all_done output replaces the individual load_done inputs of the scheduler.

Parameters:
- NUM_CH, 6, number of BRAM channels served.
- DIN_W, 32, stream word width, broadcast to all BRAMs; each BRAM uses its low bits.
- ADDR_W, 18, per-channel address and length width.
- CH_W, $clog2(NUM_CH), channel tag width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse that begins a load session
- ch_len  in  NUM_CH*ADDR_W  words expected per channel; channel i occupies bits [i*ADDR_W +: ADDR_W]; latched on accepted start
- s_valid  in  1  stream beat valid
- s_ready  out  1  stream beat accepted when s_valid & s_ready
- s_data  in  DIN_W  beat payload
- s_ch  in  CH_W  destination channel of the beat
- bram_din  out  DIN_W  registered write data
- bram_ena  out  NUM_CH  registered one-hot write enable
- bram_addra  out  ADDR_W  registered write address for the enabled channel
- load_done  out  NUM_CH  per-channel sticky done flag
- all_done  out  1  high while every channel is done
- busy  out  1  high in LOAD
- err_drop  out  1  sticky flag: a beat was discarded

Behaviour:
- Reset values: s_ready=0, bram_ena=0, bram_din=0, bram_addra=0, load_done=0, all_done=0, busy=0, err_drop=0. Internal counters and latched lengths reset to 0. FSM resets to IDLE.
- Reset is asynchronous and takes effect at any time, including mid-LOAD. In-flight beats are lost, and the session must be restarted with start.
- FSM states: IDLE, LOAD, DONE.
- IDLE -> LOAD on start.
- LOAD -> DONE on the cycle after all load_done bits are 1.
- DONE -> LOAD on start; this reloads all channels.
- start in LOAD is ignored.
- On entry to LOAD:
  - ch_len is latched.
  - Every counter cnt[i] is cleared.
  - load_done, all_done and err_drop are cleared.
- s_ready = 1 only in LOAD. It is 0 in IDLE and DONE, including the cycle in which start is sampled.
- A beat accepted at cycle t with a valid tag (s_ch < NUM_CH and cnt[s_ch] < len[s_ch]) produces:
  - at t+1: bram_ena = one-hot(s_ch), bram_addra = cnt[s_ch], bram_din = s_data;
  - cnt[s_ch] incremented.
- Write latency is one cycle. bram_ena is low in every cycle without a valid accepted beat.
- Drop rule: a beat is dropped when s_ch >= NUM_CH or cnt[s_ch] == len[s_ch].
  - A dropped beat is still handshaken, i.e. consumed.
  - No write is issued.
  - err_drop is set at t+1 and stays set until the next start.
- load_done[i]:
  - Set one cycle after the write with address len[i]-1 is issued, so the data is committed before any reader sees done.
  - A channel with len[i]==0 sets load_done[i] one cycle after LOAD entry.
  - load_done[i] holds until the next start.
- all_done = &load_done. It is registered, so it rises one cycle after the last load_done bit and coincides with entry to DONE. It stays high in DONE.
- Interleaving: beats to different channels may arrive in any order. Per-channel address order is strictly arrival order, starting at 0.
- Counters never exceed len[i]. No wrap-around is possible, because of the drop rule.
- busy = (state == LOAD).

Decomposition:
- Shared package gat_pkg holds:
  - the FSM state enum (IDLE, LOAD, DONE);
  - the channel index constants (CH_COL_IDX=0, CH_VALUE=1, CH_NODE_INFO=2, CH_WEIGHT=3, CH_A=4, CH_SPARE=5), so the top and the scheduler use one mapping.
- One sub-module, load_channel_counter, is instantiated NUM_CH times. Each instance holds:
  - the latched len and cnt;
  - the full compare;
  - the load_done register, with clear, increment and zero-length handling.
- The sequencer keeps the FSM, the tag decode, the drop/err logic and the output registers.

Test Plan:
- ch_len = {1,2,3,4,5,0}, start, then 15 beats in channel order with data = 100+k.
  - Each bram_ena fires exactly once per beat, one cycle after acceptance.
  - Addresses run 0..len-1 per channel.
  - load_done[5] rises one cycle after LOAD entry.
  - all_done rises one cycle after load_done[4].
- Interleaved tags 0,1,0,1 with ch_len[0]=ch_len[1]=2 and the others 0:
  - bram_addra sequence is 0,0,1,1;
  - bram_ena sequence is 01,10,01,10 (binary).
- Overflow: with len[0]=2, send 3 beats to channel 0.
  - The third beat is accepted and dropped, with no bram_ena.
  - err_drop = 1, and load_done[0] remains 1.
- Invalid tag: send s_ch = 7 (NUM_CH=6) during LOAD.
  - No write occurs, err_drop = 1, and all counters are unchanged.
- Backpressure and state gating:
  - s_valid held high while in IDLE gives s_ready = 0 and no writes.
  - start issued in LOAD gives no counter clear.
  - start issued in DONE clears load_done and reloads from address 0.
- Reset mid-LOAD after 3 of 5 writes:
  - All outputs are 0 immediately, asynchronously.
  - After start, the first write goes to address 0.

Source files
------------

// File: rtl/gat_pkg.sv
// gat_pkg: shared FSM state type and BRAM channel index map for the loader and scheduler.
package gat_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    localparam int CH_COL_IDX   = 0;
    localparam int CH_VALUE     = 1;
    localparam int CH_NODE_INFO = 2;
    localparam int CH_WEIGHT    = 3;
    localparam int CH_A         = 4;
    localparam int CH_SPARE     = 5;
endpackage

// File: rtl/load_channel_counter.sv
// load_channel_counter: per-channel latched length, write counter and sticky done flag.
module load_channel_counter #(
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic              inc,
    input  logic [ADDR_W-1:0] len_in,
    output logic [ADDR_W-1:0] cnt,
    output logic              full,
    output logic              done
);
    logic [ADDR_W-1:0] len;
    assign full = cnt == len;
    // done trails the final count by a cycle so the last write is committed first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len  <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else if (clr) begin
            len  <= len_in;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            if (inc) cnt <= cnt + ADDR_W'(1);
            if (en && full) done <= 1'b1;
        end
    end
endmodule

// File: rtl/bram_load_sequencer.sv
// bram_load_sequencer: steers one tagged stream into NUM_CH BRAMs, generating
// write enables, addresses and per-channel / global done flags.
module bram_load_sequencer
    import gat_pkg::*;
#(
    parameter int NUM_CH = 6,
    parameter int DIN_W  = 32,
    parameter int ADDR_W = 18,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [NUM_CH*ADDR_W-1:0] ch_len,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DIN_W-1:0]         s_data,
    input  logic [CH_W-1:0]          s_ch,
    output logic [DIN_W-1:0]         bram_din,
    output logic [NUM_CH-1:0]        bram_ena,
    output logic [ADDR_W-1:0]        bram_addra,
    output logic [NUM_CH-1:0]        load_done,
    output logic                     all_done,
    output logic                     busy,
    output logic                     err_drop
);
    state_t state, state_nx;
    logic clr, acc, drop;
    logic [NUM_CH-1:0] full, wr;
    logic [ADDR_W-1:0] cnt [NUM_CH];
    logic [ADDR_W-1:0] addr;

    assign busy    = state == LOAD;
    assign s_ready = busy;
    assign acc     = s_valid && s_ready;
    // out-of-range tags and full channels both leave wr empty, so either drops
    assign drop    = acc && !(|wr);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign wr[g] = acc && s_ch == CH_W'(g) && !full[g];
        load_channel_counter #(.ADDR_W(ADDR_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .en    (busy),
            .inc   (wr[g]),
            .len_in(ch_len[g*ADDR_W +: ADDR_W]),
            .cnt   (cnt[g]),
            .full  (full[g]),
            .done  (load_done[g])
        );
    end

    always_comb begin
        addr = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (wr[i]) addr = addr | cnt[i];
    end

    always_comb begin
        state_nx = state;
        clr      = 1'b0;
        case (state)
            IDLE, DONE: if (start) begin
                state_nx = LOAD;
                clr      = 1'b1;
            end
            LOAD: if (&load_done) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bram_ena   <= '0;
            bram_din   <= '0;
            bram_addra <= '0;
            err_drop   <= 1'b0;
            all_done   <= 1'b0;
        end else begin
            state    <= state_nx;
            bram_ena <= wr;
            if (|wr) begin
                bram_din   <= s_data;
                bram_addra <= addr;
            end
            err_drop <= !clr && (err_drop || drop);
            all_done <= !clr && &load_done;
        end
    end
endmodule

// File: tb/tb_bram_load_sequencer.sv
// tb_bram_load_sequencer: directed and random sessions checked every cycle against
// a timestamp-based model of writes, done flags and session state.
module tb_bram_load_sequencer;
    localparam int N  = 6;
    localparam int AW = 18;
    localparam int DW = 32;
    localparam longint INF = 64'd1 << 40;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, s_valid = 1'b0;
    logic [N*AW-1:0] ch_len = '0;
    logic [DW-1:0] s_data = '0;
    logic [2:0] s_ch = '0;
    logic s_ready, all_done, busy, err_drop;
    logic [DW-1:0] bram_din;
    logic [N-1:0] bram_ena, load_done;
    logic [AW-1:0] bram_addra;

    bram_load_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ch_len(ch_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_ch(s_ch),
        .bram_din(bram_din), .bram_ena(bram_ena), .bram_addra(bram_addra),
        .load_done(load_done), .all_done(all_done), .busy(busy), .err_drop(err_drop)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    longint cyc = 0;
    bit sess = 0;
    int lens[N], len[N], cnt[N];
    longint done_at[N], err_at = INF;
    logic [N-1:0] exp_ena = '0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_din = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // 0 idle, 1 loading, 2 done: the session is loading until every channel's done time has passed
    function automatic int mstate(input longint c);
        longint m = 0;
        if (!sess) return 0;
        foreach (done_at[i]) if (done_at[i] > m) m = done_at[i];
        return (c < m + 1) ? 1 : 2;
    endfunction

    task automatic model_clear();
        sess = 0;
        exp_ena = '0;
        err_at = INF;
        foreach (done_at[i]) done_at[i] = INF;
    endtask

    task automatic step(input bit st_in, input bit v, input int ch, input int d);
        int s;
        logic [N-1:0] ed;
        start = st_in; s_valid = v; s_ch = 3'(ch); s_data = DW'(d);
        for (int i = 0; i < N; i++) ch_len[i*AW +: AW] = AW'(lens[i]);
        @(posedge clk); #1;
        s = mstate(cyc);
        exp_ena = '0;
        if (v && s == 1) begin
            if (ch < N && cnt[ch] < len[ch]) begin
                exp_ena = N'(1) << ch;
                exp_addr = AW'(cnt[ch]);
                exp_din = DW'(d);
                cnt[ch]++;
                if (cnt[ch] == len[ch]) done_at[ch] = cyc + 2;
            end else if (err_at == INF) err_at = cyc + 1;
        end
        if (st_in && s != 1) begin
            sess = 1;
            err_at = INF;
            for (int i = 0; i < N; i++) begin
                len[i] = lens[i];
                cnt[i] = 0;
                done_at[i] = (lens[i] == 0) ? cyc + 2 : INF;
            end
        end
        cyc++;
        for (int i = 0; i < N; i++) ed[i] = done_at[i] <= cyc;
        chk("bram_ena", 64'(bram_ena), 64'(exp_ena));
        if (exp_ena != 0) begin
            chk("bram_addra", 64'(bram_addra), 64'(exp_addr));
            chk("bram_din", 64'(bram_din), 64'(exp_din));
        end
        chk("load_done", 64'(load_done), 64'(ed));
        chk("all_done", 64'(all_done), 64'(mstate(cyc) == 2));
        chk("busy", 64'(busy), 64'(mstate(cyc) == 1));
        chk("s_ready", 64'(s_ready), 64'(mstate(cyc) == 1));
        chk("err_drop", 64'(err_drop), 64'(err_at <= cyc));
    endtask

    task automatic check_zero();
        chk("rst_ena", 64'(bram_ena), 0);
        chk("rst_addra", 64'(bram_addra), 0);
        chk("rst_din", 64'(bram_din), 0);
        chk("rst_done", 64'(load_done), 0);
        chk("rst_all", 64'(all_done), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_ready", 64'(s_ready), 0);
        chk("rst_err", 64'(err_drop), 0);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        start = 1'b0; s_valid = 1'b0;
        #1 check_zero();
        model_clear();
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic set_lens(input int a, input int b, input int c, input int d, input int e, input int f);
        lens[0] = a; lens[1] = b; lens[2] = c; lens[3] = d; lens[4] = e; lens[5] = f;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    initial begin
        int k;
        model_clear();
        set_lens(0, 0, 0, 0, 0, 0);
        #1 check_zero();
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 1, 0, 55);

        set_lens(1, 2, 3, 4, 5, 0);
        step(1, 0, 0, 0);
        k = 0;
        for (int c = 0; c < 5; c++)
            for (int j = 0; j < lens[c]; j++) begin
                step(0, 1, c, 100 + k);
                k++;
            end
        idle(4);

        set_lens(2, 2, 0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 0, 10); step(0, 1, 1, 11); step(0, 1, 0, 12); step(0, 1, 1, 13);
        idle(4);

        set_lens(2, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 20 + i);
        idle(3);

        set_lens(3, 3, 0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 0, 30); step(0, 1, 7, 31); step(0, 1, 0, 32);
        step(1, 1, 1, 33); step(1, 0, 0, 0);
        step(0, 1, 1, 34); step(0, 1, 0, 35); step(0, 1, 1, 36);
        idle(4);

        set_lens(5, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 40 + i);
        do_reset();
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 50 + i);
        idle(4);

        for (int s = 0; s < 30; s++) begin
            for (int i = 0; i < N; i++) lens[i] = $urandom_range(0, 4);
            step(1, 0, 0, 0);
            for (int t = 0; t < 60 && mstate(cyc) != 2; t++) begin
                if ($urandom_range(0, 150) == 0) do_reset();
                step($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
                     ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7) : $urandom_range(0, N - 1),
                     int'($urandom));
            end
            step(0, $urandom_range(0, 1), $urandom_range(0, 7), int'($urandom));
            idle($urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
